// File: rtl/ip_msxbus_bridge.sv
// rtl/ip_msxbus_bridge.sv - MSX cartridge-slot to internal-bus bridge with target arbitration.
// Optional /WAIT stretching of the MSX cycle is enabled by defining MSXBUS_WAIT_EN.
module ip_msxbus_bridge #(
  parameter int SYNC_STAGES  = 2,
  parameter int FILTER_LEN   = 2,
  parameter int NUM_TARGETS  = 2,
  parameter int WAIT_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [15:0]                adr,
  input  logic [7:0]                 i_data,
  output logic [7:0]                 o_data,
  output logic                       is_output,
  input  logic                       n_sltsl,
  input  logic                       n_rd,
  input  logic                       n_wr,
  input  logic                       n_ioreq,
  input  logic                       n_mereq,
  output logic                       n_wait,
  output logic [15:0]                bus_address,
  output logic [7:0]                 bus_write_data,
  output logic                       bus_read,
  output logic                       bus_write,
  output logic                       bus_io,
  output logic                       bus_memory,
  input  logic [NUM_TARGETS-1:0]     bus_cs,
  input  logic [NUM_TARGETS-1:0]     bus_ready,
  input  logic [8*NUM_TARGETS-1:0]   bus_read_data,
  output logic                       bus_timeout
);

  localparam int SEL_W  = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int CNT_W  = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [FCNT_W-1:0] F_LAST  = FCNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0]  WT_MAX  = CNT_W'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0]  WT_LAST = CNT_W'(WAIT_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEL, S_WAIT, S_HOLD} state_t;

  state_t             state, state_next;
  logic [4:0]         raw;
  logic [4:0]         sync_q [SYNC_STAGES];
  logic [4:0]         filt;
  logic               f_sltsl, f_rd, f_wr, f_ioreq, f_mereq;
  logic               rd_d, wr_d, rd_fall, wr_fall, mem, io;
  logic               accept, hit, expire, ready_sel, rd_en, is_read;
  logic [SEL_W-1:0]   sel, sel_next;
  logic [7:0]         rdata_sel;
  logic [CNT_W-1:0]   wcnt;

  assign raw = {n_sltsl, n_rd, n_wr, n_ioreq, n_mereq};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Each filtered strobe flips only after FILTER_LEN consecutive synced samples disagree with it.
  for (genvar g = 0; g < 5; g++) begin : g_filt
    logic              f;
    logic [FCNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
      if (reset) begin
        f   <= 1'b1;
        cnt <= '0;
      end else if (sync_q[SYNC_STAGES-1][g] == f) begin
        cnt <= '0;
      end else if (cnt == F_LAST) begin
        f   <= sync_q[SYNC_STAGES-1][g];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
    assign filt[g] = f;
  end

  assign {f_sltsl, f_rd, f_wr, f_ioreq, f_mereq} = filt;
  assign mem     = ~f_sltsl & ~f_mereq;
  assign io      = ~f_ioreq;
  assign rd_fall = rd_d & ~f_rd;
  assign wr_fall = wr_d & ~f_wr;

  always_comb begin
    sel_next = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (bus_cs[i]) sel_next = SEL_W'(i);
    end
  end

  always_comb begin
    ready_sel = 1'b0;
    rdata_sel = 8'h00;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (sel == SEL_W'(i)) begin
        ready_sel = bus_ready[i];
        rdata_sel = bus_read_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    hit        = 1'b0;
    expire     = 1'b0;
    case (state)
      S_IDLE: if ((rd_fall || wr_fall) && (mem || io)) begin
        accept     = 1'b1;
        state_next = S_SEL;
      end
      S_SEL:  state_next = (|bus_cs) ? S_WAIT : S_HOLD;
      S_WAIT: begin
        if (ready_sel) begin
          hit        = 1'b1;
          state_next = S_HOLD;
        end else if (wcnt == WT_LAST) begin
          expire     = 1'b1;
          state_next = S_HOLD;
        end
      end
      S_HOLD: if (f_rd && f_wr) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      rd_d           <= 1'b1;
      wr_d           <= 1'b1;
      o_data         <= 8'h00;
      bus_address    <= 16'h0000;
      bus_write_data <= 8'h00;
      bus_read       <= 1'b0;
      bus_write      <= 1'b0;
      bus_io         <= 1'b0;
      bus_memory     <= 1'b0;
      bus_timeout    <= 1'b0;
      rd_en          <= 1'b0;
      is_read        <= 1'b0;
      sel            <= '0;
      wcnt           <= '0;
    end else begin
      state       <= state_next;
      rd_d        <= f_rd;
      wr_d        <= f_wr;
      bus_read    <= 1'b0;
      bus_write   <= 1'b0;
      bus_timeout <= 1'b0;
      if (accept) begin
        bus_address <= adr;
        if (!rd_fall) bus_write_data <= i_data;
        bus_io      <= io & ~mem;
        bus_memory  <= mem;
        is_read     <= rd_fall;
        bus_read    <= rd_fall;
        bus_write   <= ~rd_fall;
      end
      if (state == S_SEL) begin
        sel  <= sel_next;
        wcnt <= '0;
      end
      if (state == S_WAIT) begin
        if (wcnt != WT_MAX) wcnt <= wcnt + 1'b1;
        if (hit && is_read) begin
          o_data <= rdata_sel;
          rd_en  <= 1'b1;
        end else if (expire) begin
          bus_timeout <= 1'b1;
          if (is_read) begin
            o_data <= 8'hFF;
            rd_en  <= 1'b1;
          end
        end
      end
      if (state == S_HOLD && state_next == S_IDLE) begin
        bus_io     <= 1'b0;
        bus_memory <= 1'b0;
        rd_en      <= 1'b0;
      end
    end
  end

  assign is_output = rd_en & ~n_rd;

`ifdef MSXBUS_WAIT_EN
  always_ff @(posedge clk) begin
    if (reset) n_wait <= 1'b1;
    else       n_wait <= (state_next != S_WAIT);
  end
`else
  assign n_wait = 1'b1;
`endif

endmodule
